mem_io_bridge: RTL
==================

# mem_io_bridge

Data-side memory and I/O bridge sitting directly downstream of the single-cycle ARM core: it consumes the core's data address (ALUResult), WriteData and MemWrite, and returns ReadData in the same cycle. It decodes a small address map into a word RAM, an LED register, a buffered console transmit FIFO with a valid/ready output, and a free-running compare timer with a sticky interrupt flag.

## Interface
- RAM_WORDS, 64, number of 32-bit RAM words (power of two, 16..1024)
- FIFO_DEPTH, 8, console TX FIFO entries (power of two, 2..64)

- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- MemWrite  input  1  store strobe from core
- Addr  input  32  byte address (core ALUResult)
- WriteData  input  32  store data
- ReadData  output  32  combinational load data
- leds  output  8  LED register
- tx_data  output  8  FIFO head byte
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  downstream accepts tx_data this cycle
- timer_irq  output  1  sticky timer-match flag

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- Address map (Addr[1:0] ignored everywhere):
  - 0x0000_0000..RAM_WORDS*4-1: RAM, index Addr[log2(RAM_WORDS)+1:2]; R/W.
  - 0x8000_0000 LED: R/W, bits[7:0]; reads zero-extended.
  - 0x8000_0004 TXDATA: write pushes WriteData[7:0]; reads 0.
  - 0x8000_0008 STATUS: read {.., count[bits 15:8], bit2 overflow, bit1 full, bit0 empty}; write with WriteData[2]=1 clears overflow.
  - 0x8000_000C TCOUNT: R/W timer count.
  - 0x8000_0010 TCMP: R/W compare value.
  - 0x8000_0014 TCTRL: read bit0 = timer_irq; write with WriteData[0]=1 clears irq.
  - Any other address: reads 0, writes ignored.
- Reads: purely combinational from current register/RAM state; a store in the same cycle is not visible until the next cycle.
- Writes: take effect on the rising edge when MemWrite=1.
- FIFO: push on TXDATA write; pop when tx_valid && tx_ready. Push while full and no pop: byte dropped, overflow set (sticky). Push while full with pop same cycle: accepted, count unchanged, no overflow. Push and pop when not full/empty: count unchanged. Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
- Timer: 32-bit, increments by 1 each cycle, wraps 0xFFFF_FFFF->0. If TCMP!=0 and count==TCMP: count<=0 next cycle, timer_irq<=1. TCMP=0 disables match. TCOUNT write overrides increment and match in that cycle. irq set and TCTRL clear in same cycle: set wins.
- overflow set and STATUS clear same cycle: set wins.

## Timing
- Reset values: leds=0, FIFO empty (tx_valid=0, tx_data=0 from empty-slot read not guaranteed — tx_data is don't-care while tx_valid=0), overflow=0, TCOUNT=0, TCMP=0, timer_irq=0. RAM contents not reset.
- ReadData: zero-cycle latency, combinational on Addr.
- tx_valid rises the cycle after the first push into an empty FIFO; tx_data stable while tx_valid=1 and tx_ready=0.
- timer_irq asserts the cycle after the match cycle (count==TCMP on a rising edge).
- Reset asserted mid-operation overrides all writes, pushes, pops and timer activity in that cycle.

## Test plan
- Reset, store 0xDEADBEEF to 0x10, load 0x10 next cycle -> ReadData=0xDEADBEEF; load 0x8000_0020 -> 0.
- Push 0x41,0x42,0x43 with tx_ready=0 -> tx_valid=1, tx_data=0x41, STATUS count=3; raise tx_ready -> bytes leave in order, tx_valid falls after third.
- Fill FIFO (8 pushes), 9th push with tx_ready=0 -> dropped, STATUS bit2=1; 9th push with tx_ready=1 same cycle -> accepted, no overflow; write STATUS 0x4 -> overflow cleared.
- Write TCMP=5, TCOUNT=0 -> timer_irq=1 six cycles later, TCOUNT reads 0 then counts; write TCTRL 1 -> irq clears; TCMP=0 -> no irq.
- Write LED 0x1A5 -> leds=0xA5, readback 0x0000_00A5; assert reset mid-FIFO-drain -> all outputs return to reset values next cycle.
- Simultaneous irq match and TCTRL clear -> timer_irq=1.

Source files
------------

// File: rtl/mem_io_bridge.sv
// Data-side bridge for the single-cycle core: word RAM, LED register,
// console TX FIFO with valid/ready drain, and a compare timer with a sticky irq.
module mem_io_bridge #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);
    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Word addresses (Addr[31:2]) of the I/O registers
    localparam logic [29:0] LedWord   = 30'h2000_0000;
    localparam logic [29:0] TxWord    = 30'h2000_0001;
    localparam logic [29:0] StatWord  = 30'h2000_0002;
    localparam logic [29:0] TcntWord  = 30'h2000_0003;
    localparam logic [29:0] TcmpWord  = 30'h2000_0004;
    localparam logic [29:0] TctrlWord = 30'h2000_0005;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [7:0]    r_leds;
    logic [31:0]   r_tcount;
    logic [31:0]   r_tcmp;
    logic          r_irq;

    logic          w_sel_ram;
    logic [AW-1:0] w_ram_idx;
    logic          w_wr_led, w_wr_tx, w_wr_stat, w_wr_tcnt, w_wr_tcmp, w_wr_tctrl;
    logic          w_full, w_empty, w_pop, w_push, w_ovf_set, w_match;
    logic          w_unused;

    assign w_sel_ram  = (Addr[31:AW+2] == '0);
    assign w_ram_idx  = Addr[AW+1:2];
    assign w_wr_led   = MemWrite && (Addr[31:2] == LedWord);
    assign w_wr_tx    = MemWrite && (Addr[31:2] == TxWord);
    assign w_wr_stat  = MemWrite && (Addr[31:2] == StatWord);
    assign w_wr_tcnt  = MemWrite && (Addr[31:2] == TcntWord);
    assign w_wr_tcmp  = MemWrite && (Addr[31:2] == TcmpWord);
    assign w_wr_tctrl = MemWrite && (Addr[31:2] == TctrlWord);
    assign w_unused   = ^Addr[1:0];

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && tx_ready;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle
    assign w_push    = w_wr_tx && (!w_full || w_pop);
    assign w_ovf_set = w_wr_tx && w_full && !w_pop;
    assign w_match   = (r_tcmp != '0) && (r_tcount == r_tcmp);

    assign leds      = r_leds;
    assign tx_data   = r_fifo[r_rptr];
    assign tx_valid  = !w_empty;
    assign timer_irq = r_irq;

    // RAM storage, not reset
    always_ff @(posedge clk) begin
        if (!reset && MemWrite && w_sel_ram) begin
            r_ram[w_ram_idx] <= WriteData;
        end
    end

    // FIFO storage, not reset; pointers guard validity
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_fifo[r_wptr] <= WriteData[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            if (w_ovf_set)                      r_ovf <= 1'b1;
            else if (w_wr_stat && WriteData[2]) r_ovf <= 1'b0;
        end
    end

    // LED register and compare timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds   <= '0;
            r_tcount <= '0;
            r_tcmp   <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_led)  r_leds <= WriteData[7:0];
            if (w_wr_tcmp) r_tcmp <= WriteData;
            if (w_wr_tcnt)    r_tcount <= WriteData;
            else if (w_match) r_tcount <= '0;
            else              r_tcount <= r_tcount + 32'd1;
            // A software count write suppresses the match, including its irq
            if (w_match && !w_wr_tcnt)           r_irq <= 1'b1;
            else if (w_wr_tctrl && WriteData[0]) r_irq <= 1'b0;
        end
    end

    // Combinational load mux from current state
    always_comb begin
        ReadData = '0;
        if (w_sel_ram) begin
            ReadData = r_ram[w_ram_idx];
        end else begin
            case (Addr[31:2])
                LedWord:   ReadData = {24'h0, r_leds};
                StatWord:  ReadData = {16'h0, 8'(r_count), 5'h0, r_ovf, w_full, w_empty};
                TcntWord:  ReadData = r_tcount;
                TcmpWord:  ReadData = r_tcmp;
                TctrlWord: ReadData = {31'h0, r_irq};
                default:   ReadData = '0;
            endcase
        end
    end
endmodule
